// File: rtl/top_level_divider.sv
// Self-sequencing 16.8 fixed-point divider built around a small datapath:
// a 256x8 data memory, a 16x8 register file and an 8-bit program counter.
// Holding start high resets the sequencer. Dropping start runs the sequence:
// load the operands, run 24 restoring-division steps, store the quotient,
// then halt.

// 256x8 data memory: asynchronous read, synchronous write.
module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);
  logic [7:0] core [0:255];

  assign rdata = core[addr];

  // Write on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end
endmodule

// 16x8 register file: two asynchronous read ports.
// The main write port carries every load and store. The second lane writes
// only the remainder (r7), which lands on the same edge as the last quotient byte.
module reg_file (
  input  logic       clk,
  input  logic [3:0] raddr1,
  output logic [7:0] rdata1,
  input  logic [3:0] raddr2,
  output logic [7:0] rdata2,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic       we2,
  input  logic [3:0] waddr2,
  input  logic [7:0] wdata2
);
  logic [7:0] registers [0:15];

  assign rdata1 = registers[raddr1];
  assign rdata2 = registers[raddr2];

  // Synchronous writes; the two lanes never target the same register.
  always_ff @(posedge clk) begin
    if (we)  registers[waddr]  <= wdata;
    if (we2) registers[waddr2] <= wdata2;
  end
endmodule

module top_level_divider (
  input  logic CLK,
  input  logic start,
  output logic halt
);
  typedef enum logic [2:0] {
    LOAD_HI, LOAD_LO, LOAD_DV, DIV, STORE_HI, STORE_MID, STORE_LO, HALT
  } seq_t;

  seq_t        state, state_nx;
  logic [7:0]  PC;
  logic        halt_q;
  logic [4:0]  cnt;     // current dividend bit index, 23 down to 0
  logic [7:0]  rem;     // partial remainder; always below the divisor after a step
  logic [23:0] q;       // quotient shift register, MSB first

  logic        mem_we_c, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        rf_we_c, rf_we, rf_we2_c, rf_we2;
  logic [3:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic [3:0]  rf_raddr1;
  logic [7:0]  rf_rdata1, rf_rdata2;

  logic        n_bit;
  logic [8:0]  rem_sh;
  logic        ge;
  logic [7:0]  rem_nx;

  data_mem data_mem1 (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  reg_file reg_file1 (
    .clk    (CLK),
    .raddr1 (rf_raddr1),
    .rdata1 (rf_rdata1),
    .raddr2 (4'd2),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .we2    (rf_we2),
    .waddr2 (4'd7),
    .wdata2 (rem)
  );

  // Writes are suppressed while start is held, so the bench can preload safely.
  assign mem_we = mem_we_c & ~start;
  assign rf_we  = rf_we_c  & ~start;
  assign rf_we2 = rf_we2_c & ~start;
  assign halt   = halt_q;

  // One division step. N = {r0, r1, 8'h00}: bits 23..16 come from r0 and
  // bits 15..8 from r1, so cnt[2:0] indexes the selected byte.
  // Bits 7..0 of N are zero.
  // The difference always fits in 8 bits, so an 8-bit subtract is exact.
  always_comb begin
    rf_raddr1 = (cnt >= 5'd16) ? 4'd0 : 4'd1;
    n_bit     = (cnt >= 5'd8) ? rf_rdata1[cnt[2:0]] : 1'b0;
    rem_sh    = {rem, n_bit};
    ge        = rem_sh >= {1'b0, rf_rdata2};
    rem_nx    = ge ? (rem_sh[7:0] - rf_rdata2) : rem_sh[7:0];
  end

  // Next-state and datapath control for each sequencer step.
  always_comb begin
    state_nx  = state;
    mem_we_c  = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    rf_we_c   = 1'b0;
    rf_we2_c  = 1'b0;
    rf_waddr  = 4'd0;
    rf_wdata  = 8'd0;
    case (state)
      LOAD_HI: begin
        mem_addr = 8'd0; rf_we_c = 1'b1; rf_waddr = 4'd0; rf_wdata = mem_rdata;
        state_nx = LOAD_LO;
      end
      LOAD_LO: begin
        mem_addr = 8'd1; rf_we_c = 1'b1; rf_waddr = 4'd1; rf_wdata = mem_rdata;
        state_nx = LOAD_DV;
      end
      LOAD_DV: begin
        mem_addr = 8'd2; rf_we_c = 1'b1; rf_waddr = 4'd2; rf_wdata = mem_rdata;
        state_nx = DIV;
      end
      DIV: begin
        if (cnt == 5'd0) state_nx = STORE_HI;
      end
      STORE_HI: begin
        mem_we_c = 1'b1; mem_addr = 8'd4; mem_wdata = q[23:16];
        rf_we_c  = 1'b1; rf_waddr = 4'd4; rf_wdata  = q[23:16];
        state_nx = STORE_MID;
      end
      STORE_MID: begin
        mem_we_c = 1'b1; mem_addr = 8'd5; mem_wdata = q[15:8];
        rf_we_c  = 1'b1; rf_waddr = 4'd5; rf_wdata  = q[15:8];
        state_nx = STORE_LO;
      end
      STORE_LO: begin
        mem_we_c = 1'b1; mem_addr = 8'd6; mem_wdata = q[7:0];
        rf_we_c  = 1'b1; rf_waddr = 4'd6; rf_wdata  = q[7:0];
        rf_we2_c = 1'b1;
        state_nx = HALT;
      end
      HALT: state_nx = HALT;
      default: state_nx = LOAD_HI;
    endcase
  end

  // Sequencer register, PC, halt flag and divider state.
  always_ff @(posedge CLK) begin
    if (start) begin
      state  <= LOAD_HI;
      PC     <= 8'd0;
      halt_q <= 1'b0;
      cnt    <= 5'd0;
      rem    <= 8'd0;
      q      <= 24'd0;
    end else begin
      state <= state_nx;
      if (state != HALT) PC <= PC + 8'd1;
      case (state)
        LOAD_DV: begin
          rem <= 8'd0;
          q   <= 24'd0;
          cnt <= 5'd23;
        end
        DIV: begin
          rem <= rem_nx;
          q   <= {q[22:0], ge};
          cnt <= cnt - 5'd1;
        end
        STORE_LO: halt_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top_level_divider.sv
// Bench for top_level_divider. It uses a table of known divisions, random
// divisions checked against plain integer arithmetic, and hand-written abort
// and hold sequences.
module tb_top_level_divider;
  logic CLK = 1'b0;
  logic start = 1'b1;
  logic halt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_snap [0:255];
  logic [7:0] reg_snap [0:15];

  typedef struct {
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [23:0] exp_q;
    logic [7:0]  exp_rem;
    string       name;
  } vec_t;

  vec_t vecs [6];

  top_level_divider dut (
    .CLK   (CLK),
    .start (start),
    .halt  (halt)
  );

  // Clock generation.
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: quotient = (dividend * 256) / divisor, truncated.
  // A zero divisor gives all-ones, with the remainder equal to the zero fraction byte.
  function automatic logic [31:0] model(input logic [15:0] dvd, input logic [7:0] dvs);
    int unsigned n;
    int unsigned qq;
    int unsigned rr;
    n = {8'h00, dvd, 8'h00};
    if (dvs == 8'd0) return {8'h00, 24'hFFFFFF};
    qq = n / dvs;
    rr = n % dvs;
    return {rr[7:0], qq[23:0]};
  endfunction

  // Fill memory and registers with random data, then place the operands.
  // Call at a negedge while start is high.
  task automatic preload(input logic [15:0] dvd, input logic [7:0] dvs);
    for (int i = 0; i < 256; i++) begin
      mem_snap[i] = 8'($urandom_range(0, 255));
      dut.data_mem1.core[i] = mem_snap[i];
    end
    for (int i = 0; i < 16; i++) begin
      reg_snap[i] = 8'($urandom_range(0, 255));
      dut.reg_file1.registers[i] = reg_snap[i];
    end
    mem_snap[0] = dvd[15:8]; dut.data_mem1.core[0] = dvd[15:8];
    mem_snap[1] = dvd[7:0];  dut.data_mem1.core[1] = dvd[7:0];
    mem_snap[2] = dvs;       dut.data_mem1.core[2] = dvs;
    // Make sure r0 differs from core[0] so a write during reset would show.
    reg_snap[0] = ~dvd[15:8]; dut.reg_file1.registers[0] = reg_snap[0];
  endtask

  // Release start, wait for halt, and check results and untouched state.
  task automatic wait_result(input logic [23:0] eq, input logic [7:0] er, input string nm);
    int n;
    int bad;
    n = 0;
    @(negedge CLK);
    start = 1'b0;
    while (n < 60) begin
      @(posedge CLK);
      n++;
      #1;
      if (halt) break;
    end
    chk({nm, " latency"}, n, 30);
    chk({nm, " core4"}, dut.data_mem1.core[4], eq[23:16]);
    chk({nm, " core5"}, dut.data_mem1.core[5], eq[15:8]);
    chk({nm, " core6"}, dut.data_mem1.core[6], eq[7:0]);
    chk({nm, " r4"}, dut.reg_file1.registers[4], eq[23:16]);
    chk({nm, " r5"}, dut.reg_file1.registers[5], eq[15:8]);
    chk({nm, " r6"}, dut.reg_file1.registers[6], eq[7:0]);
    chk({nm, " r7"}, dut.reg_file1.registers[7], er);
    chk({nm, " r2"}, dut.reg_file1.registers[2], mem_snap[2]);
    chk({nm, " PC"}, dut.PC, 30);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if ((i < 4 || i > 6) && dut.data_mem1.core[i] !== mem_snap[i]) bad++;
    chk({nm, " mem untouched"}, bad, 0);
    bad = 0;
    for (int i = 3; i < 16; i++)
      if ((i == 3 || i > 7) && dut.reg_file1.registers[i] !== reg_snap[i]) bad++;
    chk({nm, " regs untouched"}, bad, 0);
  endtask

  task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [23:0] eq, input logic [7:0] er, input string nm);
    @(negedge CLK);
    start = 1'b1;
    preload(dvd, dvs);
    @(posedge CLK); #1;
    chk({nm, " reset halt"}, halt, 0);
    chk({nm, " reset PC"}, dut.PC, 0);
    @(posedge CLK); #1;
    chk({nm, " r0 held in reset"}, dut.reg_file1.registers[0], reg_snap[0]);
    wait_result(eq, er, nm);
  endtask

  // Launch a division, then reassert start so that the abort_edge-th edge samples it.
  task automatic launch_abort(input logic [15:0] dvd, input logic [7:0] dvs, input int abort_edge);
    @(negedge CLK);
    start = 1'b1;
    preload(dvd, dvs);
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0;
    repeat (abort_edge - 1) @(posedge CLK);
    #1;
    chk("abort PC before", dut.PC, abort_edge - 1);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK); #1;
    chk("abort halt", halt, 0);
    chk("abort PC", dut.PC, 0);
  endtask

  initial begin
    logic [15:0] rd;
    logic [7:0]  rv;
    logic [31:0] m;
    int bad_h, bad_pc, bad_m;

    vecs[0] = '{16'h0002, 8'h03, 24'h0000AA, 8'h02, "two_thirds"};
    vecs[1] = '{16'h0007, 8'h02, 24'h000380, 8'h00, "seven_halves"};
    vecs[2] = '{16'hFFFF, 8'h01, 24'hFFFF00, 8'h00, "max_div1"};
    vecs[3] = '{16'hFFFF, 8'hFF, 24'h010100, 8'h00, "max_divff"};
    vecs[4] = '{16'h1234, 8'h00, 24'hFFFFFF, 8'h00, "div_zero"};
    vecs[5] = '{16'h0100, 8'h10, 24'h001000, 8'h00, "div16"};

    for (int i = 0; i < 6; i++)
      run_div(vecs[i].dvd, vecs[i].dvs, vecs[i].exp_q, vecs[i].exp_rem, vecs[i].name);

    // Random divisions against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rd = 16'($urandom_range(0, 65535));
      rv = 8'($urandom_range(0, 255));
      m = model(rd, rv);
      run_div(rd, rv, m[23:0], m[31:24], "random");
    end

    // Abort during DIV, change the divisor, then release without clearing.
    launch_abort(16'h0100, 8'h05, 10);
    chk("abort10 core4 kept", dut.data_mem1.core[4], mem_snap[4]);
    chk("abort10 core6 kept", dut.data_mem1.core[6], mem_snap[6]);
    @(negedge CLK);
    dut.data_mem1.core[2] = 8'h10;
    mem_snap[2] = 8'h10;
    @(posedge CLK); #1;
    chk("abort10 held PC", dut.PC, 0);
    wait_result(24'h001000, 8'h00, "after_abort");

    // Hold in HALT for 20 cycles: nothing may move.
    bad_h = 0; bad_pc = 0; bad_m = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK); #1;
      if (halt !== 1'b1) bad_h++;
      if (dut.PC !== 8'd30) bad_pc++;
      if (dut.data_mem1.core[6] !== 8'h00 || dut.data_mem1.core[3] !== mem_snap[3]) bad_m++;
    end
    chk("hold halt", bad_h, 0);
    chk("hold PC", bad_pc, 0);
    chk("hold mem", bad_m, 0);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK); #1;
    chk("halt cleared by start", halt, 0);
    chk("PC cleared by start", dut.PC, 0);

    // Abort between STORE_MID and STORE_LO: only the first two bytes land.
    m = model(16'hABCD, 8'h07);
    launch_abort(16'hABCD, 8'h07, 30);
    chk("abort30 core4", dut.data_mem1.core[4], m[23:16]);
    chk("abort30 core5", dut.data_mem1.core[5], m[15:8]);
    chk("abort30 core6 kept", dut.data_mem1.core[6], mem_snap[6]);
    chk("abort30 r7 kept", dut.reg_file1.registers[7], reg_snap[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
